// File: rtl/memory_stage_pkg.sv
// Shared control definitions for the memory pipeline stage: size encodings,
// FSM states, byte-enable constants and control-vector bit positions.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam int CTL_REG_WRITE = 0;
  localparam int CTL_MEM_READ  = 1;
  localparam int CTL_MEM_WRITE = 2;
  localparam int CTL_MEM_UNS   = 3;
  localparam int CTL_W         = 4;

  // The reserved size encoding 2'b11 is handled like a word access.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    case (mem_size_e'(size))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Handshake and bus bundle of the memory stage: execute input, data-memory
// port and write-back output. master = the stage, slave = its environment.
interface memory_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [4:0]        dest_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_reg;
  logic              wb_en;
  logic              misaligned;

  modport master (
    input  in_valid, alu_result, store_data, dest_reg, reg_write,
           mem_read, mem_write, mem_size, mem_unsigned,
           dmem_ack, dmem_rdata, out_ready,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           out_valid, wb_data, wb_reg, wb_en, misaligned
  );

  modport slave (
    output in_valid, alu_result, store_data, dest_reg, reg_write,
           mem_read, mem_write, mem_size, mem_unsigned,
           dmem_ack, dmem_rdata, out_ready,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           out_valid, wb_data, wb_reg, wb_en, misaligned
  );

endinterface

// File: rtl/memory_stage_load_align.sv
// Load lane select and extension for a big-endian word: offset 0 is bits 31:24.
module load_align
  import memory_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  mem_size_e   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
    case (i_size)
      SZ_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: IDLE -> (ACCESS) -> RESP, one instruction in flight,
// big-endian byte lanes on a word-aligned data-memory port.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  memory_stage_if.master bus
);

  state_e            r_state, w_state_nxt;
  logic              r_live;
  logic [CTL_W-1:0]  w_ctl;
  logic              w_load, w_store, w_mem, w_mis, w_go_mem, w_accept, w_access;
  logic [1:0]        w_off;
  mem_size_e         w_size;
  logic [DATA_W-1:0] w_st_data, w_ld_data;
  logic [3:0]        w_st_be;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_wb_data;
  logic [3:0]        r_be;
  logic              r_we, r_load, r_uns, r_wb_en, r_mis;
  logic [1:0]        r_off;
  mem_size_e         r_size;
  logic [4:0]        r_wb_reg;

  assign w_ctl    = {bus.mem_unsigned, bus.mem_write, bus.mem_read, bus.reg_write};
  // Read wins when both read and write are asserted.
  assign w_load   = w_ctl[CTL_MEM_READ];
  assign w_store  = w_ctl[CTL_MEM_WRITE] & ~w_ctl[CTL_MEM_READ];
  assign w_mem    = w_load | w_store;
  assign w_off    = bus.alu_result[1:0];
  assign w_size   = mem_size_e'(bus.mem_size);
  assign w_mis    = w_mem & is_misaligned(bus.mem_size, w_off);
  assign w_go_mem = w_mem & ~w_mis;
  assign w_access = (r_state == ST_ACCESS);

  // r_live holds in_ready low until the first edge after reset release.
  assign bus.in_ready = r_live & (r_state == ST_IDLE);
  assign w_accept     = bus.in_valid & bus.in_ready;

  always_comb begin
    w_st_data = bus.store_data;
    w_st_be   = BE_WORD;
    case (w_size)
      SZ_BYTE: begin
        w_st_data = {4{bus.store_data[7:0]}};
        w_st_be   = BE_BYTE0 >> w_off;
      end
      SZ_HALF: begin
        w_st_data = {2{bus.store_data[15:0]}};
        w_st_be   = w_off[1] ? BE_HALF_LO : BE_HALF_HI;
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .i_rdata    (bus.dmem_rdata),
    .i_offset   (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_result   (w_ld_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)      w_state_nxt = w_go_mem ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (bus.dmem_ack)  w_state_nxt = ST_RESP;
      ST_RESP:   if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_live    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= BE_NONE;
      r_we      <= 1'b0;
      r_load    <= 1'b0;
      r_uns     <= 1'b0;
      r_off     <= 2'b00;
      r_size    <= SZ_BYTE;
      r_wb_data <= '0;
      r_wb_reg  <= '0;
      r_wb_en   <= 1'b0;
      r_mis     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_addr    <= ADDR_W'({bus.alu_result[DATA_W-1:2], 2'b00});
        r_wdata   <= w_st_data;
        r_be      <= w_go_mem ? w_st_be : BE_NONE;
        r_we      <= w_store & w_go_mem;
        r_load    <= w_load;
        r_uns     <= w_ctl[CTL_MEM_UNS];
        r_off     <= w_off;
        r_size    <= w_size;
        r_wb_data <= bus.alu_result;
        r_wb_reg  <= bus.dest_reg;
        r_wb_en   <= w_ctl[CTL_REG_WRITE] & ~w_store & ~w_mis;
        r_mis     <= w_mis;
      end
      if (w_access && bus.dmem_ack && r_load) r_wb_data <= w_ld_data;
    end
  end

  assign bus.dmem_req   = w_access;
  assign bus.dmem_we    = r_we & w_access;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;
  assign bus.dmem_be    = r_be;
  assign bus.out_valid  = (r_state == ST_RESP);
  assign bus.wb_data    = r_wb_data;
  assign bus.wb_reg     = r_wb_reg;
  assign bus.wb_en      = r_wb_en;
  assign bus.misaligned = r_mis & bus.out_valid;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// operations checked against a byte-level reference model.
module tb_memory_stage;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vec = 0;
  int   err = 0;

  memory_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic        to;
    int          lat;
    int          reqc;
    logic        stable;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic        mis;
    logic        bp_stable;
    logic        bp_rdy;
    logic        rdy_after;
  } obs_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: assemble the addressed bytes big-endian, then extend.
  function automatic logic [31:0] ref_load(logic [31:0] rd, int off, int sz, bit uns);
    logic [31:0] v;
    int nb;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    v = 0;
    for (int k = 0; k < nb; k++) v = (v << 8) | ((rd >> (8 * (3 - off - k))) & 32'hFF);
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [1:0] sz,
                        input logic uns, input logic [31:0] rdata, input int waits, input int bp,
                        output obs_t o);
    int n;
    o = '0;
    o.stable = 1'b1;
    o.bp_stable = 1'b1;
    bus.alu_result = alu; bus.store_data = sd; bus.dest_reg = rd; bus.reg_write = rw;
    bus.mem_read = mr; bus.mem_write = mw; bus.mem_size = sz; bus.mem_unsigned = uns;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    if (!bus.in_ready) o.to = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.alu_result = $urandom(); bus.store_data = $urandom(); bus.dest_reg = 5'($urandom());
    o.lat = 1;
    while (!bus.out_valid && o.lat < 100) begin
      if (bus.dmem_req) begin
        o.reqc++;
        if (o.reqc == 1) begin
          o.addr = bus.dmem_addr; o.we = bus.dmem_we; o.wdata = bus.dmem_wdata; o.be = bus.dmem_be;
        end else if ({bus.dmem_addr, bus.dmem_we, bus.dmem_wdata, bus.dmem_be} !== {o.addr, o.we, o.wdata, o.be})
          o.stable = 1'b0;
        if (o.reqc > waits) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata; end
      end
      step();
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = $urandom();
      o.lat++;
    end
    if (!bus.out_valid) o.to = 1'b1;
    o.wb_data = bus.wb_data; o.wb_reg = bus.wb_reg; o.wb_en = bus.wb_en; o.mis = bus.misaligned;
    for (int k = 0; k < bp; k++) begin
      if (bus.in_ready) o.bp_rdy = 1'b1;
      if (bus.out_valid !== 1'b1 ||
          {bus.wb_data, bus.wb_reg, bus.wb_en, bus.misaligned} !== {o.wb_data, o.wb_reg, o.wb_en, o.mis})
        o.bp_stable = 1'b0;
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    o.rdy_after = bus.in_ready;
  endtask

  task automatic test_reset();
    #2;
    vec++; if (bus.in_ready !== 1'b0) begin err++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    vec++; if ({bus.dmem_req, bus.dmem_we, bus.out_valid, bus.wb_en, bus.misaligned, bus.dmem_be} !== 9'h0) begin
      err++; $display("FAIL rst_ctrl got %b exp 0", {bus.dmem_req, bus.dmem_we, bus.out_valid, bus.wb_en, bus.misaligned, bus.dmem_be}); end
    vec++; if ({bus.dmem_addr, bus.dmem_wdata, bus.wb_data, bus.wb_reg} !== 101'h0) begin
      err++; $display("FAIL rst_data got %h/%h/%h/%h exp 0", bus.dmem_addr, bus.dmem_wdata, bus.wb_data, bus.wb_reg); end
    step(); step();
    reset_n = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b0) begin err++; $display("FAIL rst_release_early got %b exp 0", bus.in_ready); end
    step();
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL rst_first_edge got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_nonmem();
    obs_t o;
    run_op(32'h0000_0042, 32'hDEAD_0001, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 0, 0, o);
    vec++; if (o.to !== 1'b0) begin err++; $display("FAIL nm_timeout got %b exp 0", o.to); end
    vec++; if (o.lat != 1) begin err++; $display("FAIL nm_latency got %0d exp 1", o.lat); end
    vec++; if (o.reqc != 0) begin err++; $display("FAIL nm_dmem_req got %0d exp 0", o.reqc); end
    vec++; if ({o.wb_data, o.wb_reg, o.wb_en, o.mis} !== {32'h42, 5'd5, 1'b1, 1'b0}) begin
      err++; $display("FAIL nm_wb got %h/%0d/%b/%b exp 42/5/1/0", o.wb_data, o.wb_reg, o.wb_en, o.mis); end
    vec++; if (o.rdy_after !== 1'b1) begin err++; $display("FAIL nm_ready_after got %b exp 1", o.rdy_after); end
  endtask

  task automatic test_load();
    obs_t o;
    run_op(32'h0000_1001, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h12F4_5678, 3, 0, o);
    vec++; if (o.addr !== 32'h1000) begin err++; $display("FAIL lb_addr got %h exp 00001000", o.addr); end
    vec++; if (o.reqc != 4 || o.stable !== 1'b1) begin err++; $display("FAIL lb_req_hold got %0d/%b exp 4/1", o.reqc, o.stable); end
    vec++; if (o.we !== 1'b0) begin err++; $display("FAIL lb_we got %b exp 0", o.we); end
    vec++; if (o.wb_data !== 32'hFFFF_FFF4) begin err++; $display("FAIL lb_data got %h exp fffffff4", o.wb_data); end
    vec++; if ({o.wb_en, o.wb_reg, o.lat} !== {1'b1, 5'd7, 32'd5}) begin
      err++; $display("FAIL lb_wb got %b/%0d/%0d exp 1/7/5", o.wb_en, o.wb_reg, o.lat); end
    run_op(32'h0000_1001, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h12F4_5678, 3, 0, o);
    vec++; if (o.wb_data !== 32'h0000_00F4) begin err++; $display("FAIL lbu_data got %h exp 000000f4", o.wb_data); end
  endtask

  task automatic test_store();
    obs_t o;
    run_op(32'h0000_2002, 32'hAAAA_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 1, 0, o);
    vec++; if ({o.we, o.be} !== {1'b1, 4'b0011}) begin err++; $display("FAIL sh_we_be got %b/%b exp 1/0011", o.we, o.be); end
    vec++; if (o.wdata !== 32'hBEEF_BEEF) begin err++; $display("FAIL sh_wdata got %h exp beefbeef", o.wdata); end
    vec++; if (o.addr !== 32'h2000) begin err++; $display("FAIL sh_addr got %h exp 00002000", o.addr); end
    vec++; if (o.wb_en !== 1'b0 || o.stable !== 1'b1) begin err++; $display("FAIL sh_wb_en got %b/%b exp 0/1", o.wb_en, o.stable); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(32'h0000_3006, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 0, 0, o);
    vec++; if (o.reqc != 0) begin err++; $display("FAIL lw_mis_req got %0d exp 0", o.reqc); end
    vec++; if ({o.mis, o.wb_en, o.lat} !== {1'b1, 1'b0, 32'd1}) begin
      err++; $display("FAIL lw_mis_flags got %b/%b/%0d exp 1/0/1", o.mis, o.wb_en, o.lat); end
    vec++; if (o.wb_data !== 32'h3006) begin err++; $display("FAIL lw_mis_data got %h exp 00003006", o.wb_data); end
    run_op(32'h0000_0011, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 0, 0, o);
    vec++; if ({o.reqc != 0, o.mis} !== 2'b01) begin err++; $display("FAIL sh_mis got %0d/%b exp 0/1", o.reqc, o.mis); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_op(32'h1234_5678, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 0, 5, o);
    vec++; if (o.bp_stable !== 1'b1) begin err++; $display("FAIL bp_stable got %b exp 1", o.bp_stable); end
    vec++; if (o.bp_rdy !== 1'b0) begin err++; $display("FAIL bp_in_ready got %b exp 0", o.bp_rdy); end
    vec++; if (o.rdy_after !== 1'b1) begin err++; $display("FAIL bp_resume got %b exp 1", o.rdy_after); end
  endtask

  task automatic test_reset_mid_access();
    int n;
    logic seen;
    bus.alu_result = 32'h0000_4000; bus.dest_reg = 5'd9; bus.reg_write = 1'b1;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_size = 2'b10; bus.mem_unsigned = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    step();
    bus.in_valid = 1'b0;
    vec++; if (bus.dmem_req !== 1'b1) begin err++; $display("FAIL rma_req_before got %b exp 1", bus.dmem_req); end
    #2 reset_n = 1'b0;
    #1;
    vec++; if (bus.dmem_req !== 1'b0) begin err++; $display("FAIL rma_req_drop got %b exp 0", bus.dmem_req); end
    step(); step();
    vec++; if ({bus.in_ready, bus.out_valid, bus.dmem_be, bus.dmem_addr, bus.wb_data, bus.wb_en} !== 71'h0) begin
      err++; $display("FAIL rma_outputs got %b/%b/%b/%h/%h/%b exp 0", bus.in_ready, bus.out_valid, bus.dmem_be,
                      bus.dmem_addr, bus.wb_data, bus.wb_en); end
    reset_n = 1'b1;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    step(); step();
    bus.dmem_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid || bus.dmem_req) seen = 1'b1;
      step();
    end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL rma_stray_ack got %b exp 0", seen); end
    vec++; if ({bus.in_ready, bus.wb_data} !== {1'b1, 32'h0}) begin
      err++; $display("FAIL rma_idle got %b/%h exp 1/0", bus.in_ready, bus.wb_data); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 60; i++) begin
      int kind, sz, off, waits, bp;
      logic [31:0] a, sd, rdata, ew, ewd;
      logic rw, uns, mr, mw, ld, st, mis, ereq, ewe;
      logic [3:0] ebe;
      logic [4:0] rd;
      kind = $urandom_range(0, 4); sz = $urandom_range(0, 2);
      a = $urandom(); sd = $urandom(); rdata = $urandom(); rd = 5'($urandom());
      rw = 1'($urandom()); uns = 1'($urandom());
      waits = $urandom_range(0, 3); bp = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) a = (sz == 2) ? (a & ~32'h3) : (sz == 1) ? (a & ~32'h1) : a;
      mr = (kind == 1 || kind == 4); mw = (kind == 2 || kind == 4);
      off = int'(a % 4);
      ld = mr; st = mw && !mr;
      mis = (ld || st) && ((sz == 1 && off % 2 == 1) || (sz == 2 && off != 0));
      ereq = (ld || st) && !mis;
      ew = (ld && !mis) ? ref_load(rdata, off, sz, uns) : a;
      ewd = (sz == 0) ? (sd & 32'hFF) * 32'h0101_0101 : (sz == 1) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
      ebe = (sz == 0) ? 4'(1 << (3 - off)) : (sz == 1) ? ((off < 2) ? 4'hC : 4'h3) : 4'hF;
      ewe = st;
      run_op(a, sd, rd, rw, mr, mw, 2'(sz), uns, rdata, waits, bp, o);
      vec++; if (o.to !== 1'b0) begin err++; $display("FAIL rnd%0d timeout", i); end
      vec++; if ((o.reqc > 0) !== ereq) begin err++; $display("FAIL rnd%0d req got %0d exp %b", i, o.reqc, ereq); end
      vec++; if (o.lat != (ereq ? waits + 2 : 1)) begin err++; $display("FAIL rnd%0d latency got %0d exp %0d", i, o.lat, ereq ? waits + 2 : 1); end
      if (ereq) begin
        vec++; if ({o.addr, o.we, o.stable} !== {a & ~32'h3, ewe, 1'b1}) begin
          err++; $display("FAIL rnd%0d dmem got %h/%b/%b exp %h/%b/1", i, o.addr, o.we, o.stable, a & ~32'h3, ewe); end
        if (st) begin
          vec++; if ({o.wdata, o.be} !== {ewd, ebe}) begin
            err++; $display("FAIL rnd%0d store got %h/%b exp %h/%b", i, o.wdata, o.be, ewd, ebe); end
        end
      end
      vec++; if (o.wb_data !== ew) begin err++; $display("FAIL rnd%0d wb_data got %h exp %h", i, o.wb_data, ew); end
      vec++; if ({o.wb_reg, o.wb_en, o.mis} !== {rd, rw && !st && !mis, mis}) begin
        err++; $display("FAIL rnd%0d wb got %0d/%b/%b exp %0d/%b/%b", i, o.wb_reg, o.wb_en, o.mis, rd, rw && !st && !mis, mis); end
      vec++; if ({o.bp_stable, o.bp_rdy, o.rdy_after} !== 3'b101) begin
        err++; $display("FAIL rnd%0d handshake got %b exp 101", i, {o.bp_stable, o.bp_rdy, o.rdy_after}); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.alu_result = '0; bus.store_data = '0; bus.dest_reg = '0;
    bus.reg_write = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_size = 2'b00;
    bus.mem_unsigned = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0; bus.out_ready = 1'b0;
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_misaligned();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of the data-memory port.
REQ-002 Parameter: DATA_W, 32, data word width; only 32 is supported.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  in  1  execute result valid.
REQ-006 Port: in_ready  out  1  stage can accept an instruction.
REQ-007 Ports: alu_result  in  32  effective address or ALU result; store_data  in  32  rt value.
REQ-008 Ports: dest_reg  in  5  write-back register; reg_write  in  1  instruction writes a register.
REQ-009 Ports: mem_read, mem_write  in  1 each  load or store; both high is illegal and is treated as a load.
REQ-010 Ports: mem_size  in  2  00 byte, 01 halfword, 10 word; mem_unsigned  in  1  zero-extend loads.
REQ-011 Ports: dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 word-aligned; dmem_wdata  out  32; dmem_be  out  4 byte enables.
REQ-012 Ports: dmem_ack  in  1  completes the request; dmem_rdata  in  32  valid when dmem_ack is high.
REQ-013 Ports: out_valid  out  1; out_ready  in  1; wb_data  out  32; wb_reg  out  5; wb_en  out  1; misaligned  out  1.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP. in_ready=1 only in IDLE; accept occurs when in_valid&in_ready.
REQ-015 IDLE, accept of a non-memory op -> RESP next cycle, wb_data=alu_result, wb_en=reg_write (latency 1).
REQ-016 IDLE, accept of an aligned load/store -> ACCESS; dmem_req rises the cycle after accept.
REQ-017 ACCESS: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are held constant until the cycle dmem_ack=1; then -> RESP.
REQ-018 Byte lanes are big-endian: offset 0 maps to bits 31:24 and offset 3 to bits 7:0; dmem_be[3] enables bits 31:24.
REQ-019 Stores: the byte or halfword is replicated to all selected lanes; be = 1000>>off for byte, 1100 or 0011 for halfword, 1111 for word; wb_en=0.
REQ-020 Loads: the selected lane(s) of dmem_rdata are captured on ack; sign-extended unless mem_unsigned=1; wb_en=reg_write.
REQ-021 Misaligned (halfword at odd address, word at address[1:0]!=0): no dmem_req; -> RESP with misaligned=1, wb_en=0, wb_data=alu_result.
REQ-022 RESP: out_valid=1 and outputs stable until out_ready=1; -> IDLE that cycle; misaligned is valid only while out_valid=1.
REQ-023 dmem_ack outside ACCESS is ignored.
REQ-024 Throughput: at most one instruction per 2 cycles (non-memory) or per 3+wait cycles (memory); no bypass from RESP to IDLE.

Reset
REQ-025 While reset_n=0: state=IDLE; in_ready=0; dmem_req, dmem_we, out_valid, wb_en, misaligned=0; dmem_be=0000; dmem_addr, dmem_wdata, wb_data=0; wb_reg=0.
REQ-026 Reset asserted mid-ACCESS drops dmem_req immediately; the pending transaction is abandoned and an ack after reset release is ignored.
REQ-027 in_ready rises the first clock edge after reset_n deasserts.

Structure
REQ-028 mem_size encodings, the FSM state enumeration and the byte-enable constants live in the shared control package alongside the existing control-vector bit indices.
REQ-029 Load alignment/extension is a sub-module, load_align (combinational: rdata, offset, size, unsigned -> 32-bit result); the store lane builder stays inline.

Verification
REQ-030 Non-memory op: alu_result=0x0000_0042, reg_write=1, dest_reg=5, out_ready=1 -> out_valid 1 cycle after accept, wb_data=0x42, wb_reg=5, wb_en=1, no dmem_req.
REQ-031 lb at 0x1001, dmem_rdata=0x12F4_5678, ack after 3 wait cycles -> dmem_addr=0x1000, dmem_req held 4 cycles, wb_data=0xFFFF_FFF4; lbu gives 0x0000_00F4.
REQ-032 sh at 0x2002, store_data=0xAAAA_BEEF -> dmem_we=1, dmem_be=0011, dmem_wdata=0xBEEF_BEEF, wb_en=0.
REQ-033 lw at 0x3006 -> no dmem_req, out_valid with misaligned=1, wb_en=0.
REQ-034 Back-pressure: out_ready=0 for 5 cycles in RESP -> outputs stable, in_ready=0 throughout; accept resumes the cycle after out_ready=1.
REQ-035 reset_n pulsed low during ACCESS, stray ack afterwards -> all outputs at reset values, state IDLE, no out_valid produced.
